// File: rtl/wb_result_arbiter_if.sv
// Bundle of the execution-unit request side and the writeback output stage
// of wb_result_arbiter; master = units/consumer, slave = arbiter.
interface wb_result_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int XLEN      = 32,
  parameter int ID_W      = 3
);
  localparam int SRC_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0]           unit_done;
  logic [NUM_UNITS-1:0][XLEN-1:0] unit_rd;
  logic [NUM_UNITS-1:0][ID_W-1:0] unit_id;
  logic [NUM_UNITS-1:0]           unit_accepted;
  logic                           wb_valid;
  logic [XLEN-1:0]                wb_rd;
  logic [ID_W-1:0]                wb_id;
  logic [SRC_W-1:0]               wb_src;
  logic                           wb_ready;

  modport master (
    output unit_done, unit_rd, unit_id, wb_ready,
    input  unit_accepted, wb_valid, wb_rd, wb_id, wb_src
  );

  modport slave (
    input  unit_done, unit_rd, unit_id, wb_ready,
    output unit_accepted, wb_valid, wb_rd, wb_id, wb_src
  );
endinterface

// File: rtl/wb_result_arbiter.sv
// Writeback arbiter: one grant per cycle into a single-entry output stage.
// Define WB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
module wb_result_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int XLEN      = 32,
  parameter int ID_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  wb_result_arbiter_if.slave  bus
);
  localparam int SRC_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic             free;
  logic             found;
  logic             grant;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;
  logic [NUM_UNITS-1:0] acc_vec;

  logic             valid_q;
  logic [XLEN-1:0]  rd_q;
  logic [ID_W-1:0]  id_q;
  logic [SRC_W-1:0] src_q;

  logic [15:0] accept_count [NUM_UNITS];

`ifdef WB_ROUND_ROBIN_EN
  logic [SRC_W-1:0] rr_ptr;
`endif

  // Pick the winner among requesting units; only meaningful when free.
  always_comb begin
    free      = ~valid_q | bus.wb_ready;
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
`ifdef WB_ROUND_ROBIN_EN
      cand = SRC_W'((int'(rr_ptr) + i) % NUM_UNITS);
`else
      cand = SRC_W'(i);
`endif
      if (!found && bus.unit_done[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant = free & found;
  end

  // The grant pulse is suppressed while reset is held so no unit retires a lost result.
  always_comb begin
    acc_vec = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      acc_vec[i] = grant && rst && (grant_idx == SRC_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      id_q    <= '0;
      src_q   <= '0;
    end else if (grant) begin
      valid_q <= 1'b1;
      rd_q    <= bus.unit_rd[grant_idx];
      id_q    <= bus.unit_id[grant_idx];
      src_q   <= grant_idx;
    end else if (bus.wb_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_UNITS; i++) accept_count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (grant && (grant_idx == SRC_W'(i)) && (accept_count[i] != 16'hFFFF)) begin
          accept_count[i] <= accept_count[i] + 16'd1;
        end
      end
    end
  end

`ifdef WB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (int'(grant_idx) == NUM_UNITS - 1) ? '0 : grant_idx + SRC_W'(1);
    end
  end
`endif

  assign bus.unit_accepted = acc_vec;
  assign bus.wb_valid      = valid_q;
  assign bus.wb_rd         = rd_q;
  assign bus.wb_id         = id_q;
  assign bus.wb_src        = src_q;
endmodule

// File: tb/tb_wb_result_arbiter.sv
// Self-checking bench for wb_result_arbiter (4 units, 32-bit results, 3-bit IDs);
// honours WB_ROUND_ROBIN_EN when choosing expected grants.
module tb_wb_result_arbiter;
  localparam int N = 4;

  typedef struct {
    logic [3:0]  done;
    logic [31:0] rd;
    logic [2:0]  id;
    logic [3:0]  exp_acc;
    logic [1:0]  exp_src;
  } vec_t;

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  id;
    logic [31:0] rd;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vec_t table_v [6];
  exp_t tq [$];
  exp_t uq [N][$];

  wb_result_arbiter_if #(.NUM_UNITS(N), .XLEN(32), .ID_W(3)) bus ();

  wb_result_arbiter #(.NUM_UNITS(N), .XLEN(32), .ID_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input int u, input logic done, input logic [31:0] rd, input logic [2:0] id);
    bus.unit_done[u] = done;
    bus.unit_rd[u]   = rd;
    bus.unit_id[u]   = id;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b0;
    bus.unit_done = '0;
    bus.wb_ready  = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    exp_t e;
    logic [3:0] exp_acc;
    logic [31:0] cur_rd [N];
    logic [2:0]  cur_id [N];
    logic [2:0]  seq [N];
    logic [3:0]  acc_prev;
    int prev_g, exp_g, rr_p, generated, received, grants, sum;
    logic [31:0] prev_rd;

    checks = 0;
    errors = 0;
    bus.unit_done = '0;
    bus.unit_rd   = '0;
    bus.unit_id   = '0;
    bus.wb_ready  = 1'b0;

    table_v[0] = '{4'b0010, 32'h1111_0001, 3'd1, 4'b0010, 2'd1};
    table_v[1] = '{4'b1000, 32'h3333_0003, 3'd3, 4'b1000, 2'd3};
    table_v[2] = '{4'b0100, 32'h2222_0002, 3'd5, 4'b0100, 2'd2};
    table_v[3] = '{4'b0001, 32'h0000_00FF, 3'd7, 4'b0001, 2'd0};
    table_v[4] = '{4'b1000, 32'hDEAD_BEEF, 3'd0, 4'b1000, 2'd3};
    table_v[5] = '{4'b0010, 32'hFFFF_FFFF, 3'd6, 4'b0010, 2'd1};

    // Reset state, with a request held to show the grant is masked
    rst = 1'b1;
    #1 rst = 1'b0;
    apply_stimulus(0, 1'b1, 32'h5, 3'd1);
    bus.wb_ready = 1'b1;
    #2;
    check_output("reset_accepted", bus.unit_accepted, 4'b0000);
    check_output("reset_valid", bus.wb_valid, 1'b0);
    check_output("reset_rd", bus.wb_rd, 32'h0);
    check_output("reset_id", bus.wb_id, 3'd0);
    check_output("reset_src", bus.wb_src, 2'd0);
    bus.unit_done = '0;
    next_cycle();
    next_cycle();
    rst = 1'b1;

    // Single request with same-cycle accept and next-cycle output
    next_cycle();
    apply_stimulus(0, 1'b1, 32'h0000_000A, 3'd2);
    bus.wb_ready = 1'b1;
    #3 check_output("single_accepted", bus.unit_accepted, 4'b0001);
    next_cycle();
    bus.unit_done[0] = 1'b0;
    #3;
    check_output("single_valid", bus.wb_valid, 1'b1);
    check_output("single_rd", bus.wb_rd, 32'h0000_000A);
    check_output("single_id", bus.wb_id, 3'd2);
    check_output("single_src", bus.wb_src, 2'd0);
    check_output("single_acc_idle", bus.unit_accepted, 4'b0000);
    next_cycle();
    #3;
    check_output("drain_valid", bus.wb_valid, 1'b0);
    check_output("drain_rd_held", bus.wb_rd, 32'h0000_000A);

    // Table vectors, back-to-back with wb_ready held high
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      bus.unit_done = '0;
      for (int u = 0; u < N; u++)
        if (table_v[k].done[u]) apply_stimulus(u, 1'b1, table_v[k].rd, table_v[k].id);
      #3;
      check_output($sformatf("table%0d_accepted", k), bus.unit_accepted, table_v[k].exp_acc);
      check_output($sformatf("table%0d_valid", k), bus.wb_valid, tq.size() > 0);
      if (tq.size() > 0) begin
        e = tq.pop_front();
        check_output($sformatf("table%0d_src", k), bus.wb_src, e.src);
        check_output($sformatf("table%0d_id", k), bus.wb_id, e.id);
        check_output($sformatf("table%0d_rd", k), bus.wb_rd, e.rd);
      end
      e.src = table_v[k].exp_src;
      e.id  = table_v[k].id;
      e.rd  = table_v[k].rd;
      tq.push_back(e);
    end
    next_cycle();
    bus.unit_done = '0;
    #3;
    e = tq.pop_front();
    check_output("table_last_src", bus.wb_src, e.src);
    check_output("table_last_rd", bus.wb_rd, e.rd);
    check_output("table_last_acc", bus.unit_accepted, 4'b0000);

    // Contention: all four units request, re-presenting after each accept
    do_reset();
    for (int u = 0; u < N; u++) begin
      cur_rd[u] = 32'hC000_0000 | (u << 8);
      cur_id[u] = 3'(u);
    end
    bus.wb_ready = 1'b1;
    prev_g  = 0;
    prev_rd = '0;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      if (c > 0) begin
        cur_rd[prev_g] = cur_rd[prev_g] + 32'd1;
        cur_id[prev_g] = cur_id[prev_g] + 3'd1;
      end
      for (int u = 0; u < N; u++) apply_stimulus(u, 1'b1, cur_rd[u], cur_id[u]);
      #3;
`ifdef WB_ROUND_ROBIN_EN
      exp_g = c % N;
`else
      exp_g = 0;
`endif
      check_output($sformatf("contend%0d_accepted", c), bus.unit_accepted, 4'b0001 << exp_g);
      if (c > 0) begin
        check_output($sformatf("contend%0d_src", c), bus.wb_src, 2'(prev_g));
        check_output($sformatf("contend%0d_rd", c), bus.wb_rd, prev_rd);
      end
      prev_g  = exp_g;
      prev_rd = cur_rd[exp_g];
    end
    next_cycle();
    bus.unit_done = '0;
    #3;
    check_output("contend_last_src", bus.wb_src, 2'(prev_g));
    check_output("contend_last_rd", bus.wb_rd, prev_rd);
`ifdef WB_ROUND_ROBIN_EN
    check_output("contend_count0", dut.accept_count[0], 16'd2);
    check_output("contend_count3", dut.accept_count[3], 16'd1);
`else
    check_output("contend_count0", dut.accept_count[0], 16'd5);
    check_output("contend_count3", dut.accept_count[3], 16'd0);
`endif

    // Stall: output held, no grants while wb_ready is low
    do_reset();
    apply_stimulus(0, 1'b1, 32'h1234_5678, 3'd4);
    bus.wb_ready = 1'b0;
    #3 check_output("stall_first_acc", bus.unit_accepted, 4'b0001);
    next_cycle();
    bus.unit_done[0] = 1'b0;
    apply_stimulus(1, 1'b1, 32'hBEEF_0001, 3'd5);
    for (int c = 0; c < 5; c++) begin
      #3;
      check_output($sformatf("stall%0d_acc", c), bus.unit_accepted, 4'b0000);
      check_output($sformatf("stall%0d_valid", c), bus.wb_valid, 1'b1);
      check_output($sformatf("stall%0d_rd", c), bus.wb_rd, 32'h1234_5678);
      check_output($sformatf("stall%0d_src", c), bus.wb_src, 2'd0);
      next_cycle();
    end
    bus.wb_ready = 1'b1;
    #3 check_output("unstall_acc", bus.unit_accepted, 4'b0010);
    next_cycle();
    bus.unit_done[1] = 1'b0;
    #3;
    check_output("unstall_valid", bus.wb_valid, 1'b1);
    check_output("unstall_rd", bus.wb_rd, 32'hBEEF_0001);
    check_output("unstall_id", bus.wb_id, 3'd5);
    check_output("unstall_src", bus.wb_src, 2'd1);

    // Simultaneous drain and grant, no bubble
    next_cycle();
    apply_stimulus(2, 1'b1, 32'hCAFE_0002, 3'd6);
    #3 check_output("dg_acc", bus.unit_accepted, 4'b0100);
    next_cycle();
    bus.unit_done[2] = 1'b0;
    bus.wb_ready = 1'b0;
    #3;
    check_output("dg_valid", bus.wb_valid, 1'b1);
    check_output("dg_rd", bus.wb_rd, 32'hCAFE_0002);
    check_output("dg_src", bus.wb_src, 2'd2);

    // Asynchronous reset between edges while the stage is full and a grant is live
    next_cycle();
    apply_stimulus(3, 1'b1, 32'h7777_0003, 3'd3);
    bus.wb_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_output("areset_valid", bus.wb_valid, 1'b0);
    check_output("areset_rd", bus.wb_rd, 32'h0);
    check_output("areset_src", bus.wb_src, 2'd0);
    check_output("areset_acc", bus.unit_accepted, 4'b0000);
    bus.unit_done = '0;
    next_cycle();
    rst = 1'b1;
    #3;
    check_output("areset_post_valid", bus.wb_valid, 1'b0);
    check_output("areset_count2", dut.accept_count[2], 16'd0);
`ifdef WB_ROUND_ROBIN_EN
    check_output("areset_ptr", dut.rr_ptr, 2'd0);
`endif

    // Random traffic: 1000 results, per-unit scoreboard queues and a grant model
    do_reset();
    acc_prev  = '0;
    rr_p      = 0;
    generated = 0;
    received  = 0;
    grants    = 0;
    for (int u = 0; u < N; u++) seq[u] = '0;
    for (int cyc = 0; cyc < 20000 && received < 1000; cyc++) begin
      next_cycle();
      for (int u = 0; u < N; u++) begin
        if (acc_prev[u]) bus.unit_done[u] = 1'b0;
        if (!bus.unit_done[u] && generated < 1000 && $urandom_range(1, 0) == 1) begin
          seq[u] = seq[u] + 3'd1;
          apply_stimulus(u, 1'b1, $urandom, seq[u]);
          e.src = 2'(u);
          e.id  = seq[u];
          e.rd  = bus.unit_rd[u];
          uq[u].push_back(e);
          generated++;
        end
      end
      bus.wb_ready = ($urandom_range(9, 0) < 7);
      #3;
      exp_acc = '0;
      if ((!bus.wb_valid || bus.wb_ready) && bus.unit_done != '0) begin
        exp_g = -1;
`ifdef WB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++)
          if (exp_g < 0 && bus.unit_done[(rr_p + k) % N]) exp_g = (rr_p + k) % N;
        rr_p = (exp_g + 1) % N;
`else
        for (int k = N - 1; k >= 0; k--)
          if (bus.unit_done[k]) exp_g = k;
`endif
        exp_acc[exp_g] = 1'b1;
        grants++;
      end
      check_output("rand_accepted", bus.unit_accepted, exp_acc);
      if (bus.wb_valid && bus.wb_ready) begin
        if (uq[bus.wb_src].size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rand_unexpected: unit %0d produced id %0d with nothing outstanding", bus.wb_src, bus.wb_id);
        end else begin
          e = uq[bus.wb_src].pop_front();
          check_output("rand_id", bus.wb_id, e.id);
          check_output("rand_rd", bus.wb_rd, e.rd);
        end
        received++;
      end
      acc_prev = bus.unit_accepted;
    end
    check_output("rand_received", received, 1000);
    check_output("rand_grants", grants, 1000);
    sum = 0;
    for (int u = 0; u < N; u++) sum += int'(dut.accept_count[u]);
    check_output("rand_count_sum", sum, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
